// File: rtl/control_path_multi.sv
// Control path for a multi-field counter datapath: timed preset sequence,
// carry-chained increment and sequential load, all strobes from registers.
module control_path_multi #(
    parameter int NUM_FIELDS   = 4,
    parameter int FIELD_W      = 4,
    parameter int SEL_W        = 2,
    parameter int DWELL        = 3,
    parameter int PRESET_START = 6,
    parameter int PRESET_STEP  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            on,
    input  logic                  start,
    input  logic [NUM_FIELDS-1:0] f_wrap,
    output logic [1:0]            regime,
    output logic                  active,
    output logic [SEL_W-1:0]      f_sel,
    output logic [1:0]            f_op,
    output logic [FIELD_W-1:0]    f_const,
    output logic [NUM_FIELDS-1:0] f_inc,
    output logic [NUM_FIELDS-1:0] f_clr,
    output logic                  done
);

    typedef enum logic [3:0] {
        S_OFF, S_P_ARM, S_P_WRITE, S_P_DWELL, S_P_RESTORE, S_P_FIN,
        S_COUNT, S_LOAD, S_L_FIN
    } state_t;

    localparam logic [FIELD_W-1:0] START_V = FIELD_W'(PRESET_START);
    localparam logic [FIELD_W-1:0] STEP_V  = FIELD_W'(PRESET_STEP);
    localparam logic [3:0]         DWELL_LAST = 4'(DWELL - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_FIELDS - 1);

    state_t                  state_reg, state_next;
    logic [FIELD_W-1:0]      v_reg, v_next;
    logic                    last_reg, last_next;
    logic [3:0]              dwell_reg, dwell_next;
    logic [SEL_W-1:0]        idx_reg, idx_next;

    logic [1:0]              regime_reg, regime_next;
    logic                    active_reg, active_next;
    logic [SEL_W-1:0]        sel_reg, sel_next;
    logic [1:0]              op_reg, op_next;
    logic [FIELD_W-1:0]      const_reg, const_next;
    logic [NUM_FIELDS-1:0]   inc_reg, inc_next;
    logic [NUM_FIELDS-1:0]   clr_reg, clr_next;
    logic                    done_reg, done_next;

    // Field i increments only when every lower field is wrapping.
    logic [NUM_FIELDS-1:0]   inc_chain;
    assign inc_chain[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < NUM_FIELDS; gi++) begin : g_carry
            assign inc_chain[gi] = inc_chain[gi-1] & f_wrap[gi-1];
        end
    endgenerate

    function automatic logic [1:0] regime_of(input state_t s);
        case (s)
            S_P_ARM, S_P_WRITE, S_P_DWELL, S_P_RESTORE, S_P_FIN: regime_of = 2'd1;
            S_COUNT:                                             regime_of = 2'd2;
            S_LOAD, S_L_FIN:                                     regime_of = 2'd3;
            default:                                             regime_of = 2'd0;
        endcase
    endfunction

    always_comb begin
        state_next  = state_reg;
        v_next      = v_reg;
        last_next   = last_reg;
        dwell_next  = dwell_reg;
        idx_next    = idx_reg;
        active_next = active_reg;
        sel_next    = '0;
        op_next     = 2'b00;
        const_next  = '0;
        inc_next    = '0;
        clr_next    = '0;
        done_next   = 1'b0;

        case (state_reg)
            S_OFF: begin
                active_next = 1'b0;
                case (on)
                    2'd1:    state_next = S_P_ARM;
                    2'd2:    state_next = S_COUNT;
                    2'd3: begin
                        state_next = S_LOAD;
                        idx_next   = '0;
                    end
                    default: state_next = S_OFF;
                endcase
            end
            S_P_ARM: begin
                if (start) begin
                    active_next = 1'b1;
                    v_next      = START_V;
                    state_next  = S_P_WRITE;
                end
            end
            S_P_WRITE: begin
                op_next    = 2'b01;
                const_next = v_reg;
                dwell_next = '0;
                // Decide now whether this is the final value; the old v is lost after decrement.
                last_next  = (v_reg < STEP_V);
                if (!(v_reg < STEP_V))
                    v_next = v_reg - STEP_V;
                if (DWELL > 0)
                    state_next = S_P_DWELL;
                else
                    state_next = (v_reg < STEP_V) ? S_P_RESTORE : S_P_WRITE;
            end
            S_P_DWELL: begin
                if (dwell_reg == DWELL_LAST)
                    state_next = last_reg ? S_P_RESTORE : S_P_WRITE;
                else
                    dwell_next = dwell_reg + 4'd1;
            end
            S_P_RESTORE: begin
                op_next    = 2'b01;
                const_next = START_V;
                state_next = S_P_FIN;
            end
            S_P_FIN: begin
                active_next = 1'b0;
                done_next   = 1'b1;
                state_next  = S_OFF;
            end
            S_COUNT: begin
                if (start) begin
                    op_next  = 2'b10;
                    inc_next = inc_chain;
                    clr_next = inc_chain & f_wrap;
                end else begin
                    state_next = S_OFF;
                end
            end
            S_LOAD: begin
                op_next  = 2'b11;
                sel_next = idx_reg;
                if (idx_reg == SEL_LAST)
                    state_next = S_L_FIN;
                else
                    idx_next = idx_reg + 1'b1;
            end
            S_L_FIN: begin
                done_next  = 1'b1;
                state_next = S_OFF;
            end
            default: state_next = S_OFF;
        endcase

        regime_next = regime_of(state_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_OFF;
            v_reg      <= '0;
            last_reg   <= 1'b0;
            dwell_reg  <= '0;
            idx_reg    <= '0;
            regime_reg <= 2'd0;
            active_reg <= 1'b0;
            sel_reg    <= '0;
            op_reg     <= 2'b00;
            const_reg  <= '0;
            inc_reg    <= '0;
            clr_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            v_reg      <= v_next;
            last_reg   <= last_next;
            dwell_reg  <= dwell_next;
            idx_reg    <= idx_next;
            regime_reg <= regime_next;
            active_reg <= active_next;
            sel_reg    <= sel_next;
            op_reg     <= op_next;
            const_reg  <= const_next;
            inc_reg    <= inc_next;
            clr_reg    <= clr_next;
            done_reg   <= done_next;
        end
    end

    assign regime  = regime_reg;
    assign active  = active_reg;
    assign f_sel   = sel_reg;
    assign f_op    = op_reg;
    assign f_const = const_reg;
    assign f_inc   = inc_reg;
    assign f_clr   = clr_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_control_path_multi.sv
// Bench for control_path_multi: two parameterisations driven with random
// stimulus and compared cycle by cycle against a trace built from the rules.
module tb_control_path_multi;

    localparam int NF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    on_a, on_b;
    logic          start_a, start_b;
    logic [NF-1:0] wrap_a, wrap_b;

    logic [1:0] regime_a, regime_b, f_sel_a, f_sel_b, f_op_a, f_op_b;
    logic       active_a, active_b, done_a, done_b;
    logic [3:0] f_const_a, f_const_b;
    logic [NF-1:0] f_inc_a, f_inc_b, f_clr_a, f_clr_b;

    int vectors = 0;
    int miscompares = 0;

    control_path_multi dut_a (
        .clk(clk), .rst(rst), .on(on_a), .start(start_a), .f_wrap(wrap_a),
        .regime(regime_a), .active(active_a), .f_sel(f_sel_a), .f_op(f_op_a),
        .f_const(f_const_a), .f_inc(f_inc_a), .f_clr(f_clr_a), .done(done_a)
    );

    control_path_multi #(.DWELL(0), .PRESET_START(1), .PRESET_STEP(2)) dut_b (
        .clk(clk), .rst(rst), .on(on_b), .start(start_b), .f_wrap(wrap_b),
        .regime(regime_b), .active(active_b), .f_sel(f_sel_b), .f_op(f_op_b),
        .f_const(f_const_b), .f_inc(f_inc_b), .f_clr(f_clr_b), .done(done_b)
    );

    function automatic int dwell_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction
    function automatic int pstart_of(input int d);
        return (d == 0) ? 6 : 1;
    endfunction
    function automatic int pstep_of(input int d);
        return 2;
    endfunction

    // Packed view: regime, active, f_sel, f_op, f_const, f_inc, f_clr, done
    function automatic logic [19:0] pk(input logic [1:0] r, input logic a, input logic [1:0] s,
                                       input logic [1:0] op, input logic [3:0] c,
                                       input logic [3:0] inc, input logic [3:0] clr, input logic dn);
        return {r, a, s, op, c, inc, clr, dn};
    endfunction

    function automatic logic [19:0] obs(input int d);
        if (d == 0)
            return {regime_a, active_a, f_sel_a, f_op_a, f_const_a, f_inc_a, f_clr_a, done_a};
        return {regime_b, active_b, f_sel_b, f_op_b, f_const_b, f_inc_b, f_clr_b, done_b};
    endfunction

    // Increment mask from the carry rule: field i steps when all lower fields wrap.
    function automatic logic [3:0] model_inc(input logic [3:0] w);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < NF; i++) begin
            int mask = (1 << i) - 1;
            if ((int'(w) & mask) == mask) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic drive(input int d, input logic [1:0] o, input logic st, input logic [3:0] w);
        if (d == 0) begin
            on_a = o; start_a = st; wrap_a = w;
        end else begin
            on_b = o; start_b = st; wrap_b = w;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] got;
        drive(0, 2'd0, 1'b0, 4'd0);
        drive(1, 2'd0, 1'b0, 4'd0);
        rst = 1'b1;
        tick; tick;
        for (int d = 0; d < 2; d++) begin
            got = obs(d);
            vectors++;
            if (got !== 20'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %h expected %h", d, got, 20'd0);
            end
        end
        rst = 1'b0;
        // Reach the first dwell cycle of a preset, then reset asynchronously.
        drive(0, 2'd1, 1'b1, 4'd0);
        tick; tick; tick; tick;
        vectors++;
        if (active_a !== 1'b1 || f_op_a !== 2'b00) begin
            miscompares++;
            $display("FAIL dwell_precondition: got active=%b op=%b expected active=1 op=00", active_a, f_op_a);
        end
        #2 rst = 1'b1;
        #1;
        got = obs(0);
        vectors++;
        if (got !== 20'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", got, 20'd0);
        end
        drive(0, 2'd0, 1'b0, 4'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick;
            got = obs(0);
            vectors++;
            if (got !== 20'd0) begin
                miscompares++;
                $display("FAIL post_reset_off[%0d]: got %h expected %h", k, got, 20'd0);
            end
        end
    endtask

    task automatic test_preset(input int d);
        logic [19:0] q[$];
        logic [19:0] got;
        int ad = $urandom_range(0, 3);
        int v  = pstart_of(d);
        int last;
        q.push_back(pk(2'd1, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0));
        for (int i = 0; i < ad; i++)
            q.push_back(pk(2'd1, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0));
        q.push_back(pk(2'd1, 1'b1, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0));
        forever begin
            q.push_back(pk(2'd1, 1'b1, 2'd0, 2'b01, 4'(v), 4'd0, 4'd0, 1'b0));
            for (int i = 0; i < dwell_of(d); i++)
                q.push_back(pk(2'd1, 1'b1, 2'd0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0));
            if (v < pstep_of(d)) break;
            v = v - pstep_of(d);
        end
        q.push_back(pk(2'd1, 1'b1, 2'd0, 2'b01, 4'(pstart_of(d)), 4'd0, 4'd0, 1'b0));
        q.push_back(pk(2'd0, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1));
        q.push_back(pk(2'd0, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0));
        last = q.size() - 1;
        for (int k = 0; k <= last; k++) begin
            logic [1:0] o;
            logic st;
            o  = (k == 0) ? 2'd1 : (k == last) ? 2'd0 : 2'($urandom_range(0, 3));
            st = (k <= ad) ? 1'b0 : (k == ad + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(d, o, st, 4'($urandom_range(0, 15)));
            tick;
            got = obs(d);
            vectors++;
            if (got !== q[k]) begin
                miscompares++;
                $display("FAIL preset%0d[%0d]: got %h expected %h", d, k, got, q[k]);
            end
        end
    endtask

    task automatic test_count(input int n);
        logic [19:0] got, exp;
        logic [3:0] w, inc;
        drive(0, 2'd2, 1'b1, 4'd0);
        tick;
        exp = pk(2'd2, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        got = obs(0);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL count_enter: got %h expected %h", got, exp);
        end
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? 4'b0001 : (k == 1) ? 4'b1111 : (k == 2) ? 4'b0111 : 4'($urandom_range(0, 15));
            drive(0, 2'($urandom_range(0, 3)), 1'b1, w);
            tick;
            inc = model_inc(w);
            exp = pk(2'd2, 1'b0, 2'd0, 2'b10, 4'd0, inc, inc & w, 1'b0);
            got = obs(0);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL count[%0d] wrap=%b: got %h expected %h", k, w, got, exp);
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 2'd0, 1'b0, 4'($urandom_range(0, 15)));
            tick;
            got = obs(0);
            vectors++;
            if (got !== 20'd0) begin
                miscompares++;
                $display("FAIL count_exit[%0d]: got %h expected %h", k, got, 20'd0);
            end
        end
    endtask

    task automatic test_load(input int d);
        logic [19:0] got, exp;
        for (int k = 0; k <= NF + 2; k++) begin
            logic [1:0] o;
            o = (k == 0) ? 2'd3 : (k == NF + 2) ? 2'd0 : 2'($urandom_range(0, 3));
            drive(d, o, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick;
            if (k == 0)
                exp = pk(2'd3, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
            else if (k <= NF)
                exp = pk(2'd3, 1'b0, 2'(k - 1), 2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
            else if (k == NF + 1)
                exp = pk(2'd0, 1'b0, 2'd0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1);
            else
                exp = 20'd0;
            got = obs(d);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL load%0d[%0d]: got %h expected %h", d, k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        test_load(0);
        test_preset(0);
        test_count(8);
        test_load(0);
    endtask

    initial begin
        drive(0, 2'd0, 1'b0, 4'd0);
        drive(1, 2'd0, 1'b0, 4'd0);
        test_reset;
        test_preset(0);
        test_count(24);
        test_load(0);
        test_preset(1);
        test_load(1);
        test_back_to_back;
        for (int r = 0; r < 3; r++) begin
            test_preset(r % 2);
            test_load(1 - (r % 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
